// File: rtl/ssd_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display feeder.
package ssd_bcd_pkg;

    localparam int unsigned BIN_W      = 8;
    localparam int unsigned ITER_COUNT = 8;
    localparam int unsigned BCD_DIGITS = 3;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_e;

    typedef logic [BCD_W-1:0] bcd_t;

    // Double-dabble correction applied to one BCD nibble before the shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: per-nibble add-3, then shift {bcd, bin} left by one.
module bcd_dabble_step
    import ssd_bcd_pkg::*;
(
    input  bcd_t             bcd_i,
    input  logic [BIN_W-1:0] bin_i,
    output bcd_t             bcd_o,
    output logic [BIN_W-1:0] bin_o
);

    bcd_t                   adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    always_comb begin
        adj = '0;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            adj[4*d +: 4] = add3(bcd_i[4*d +: 4]);
        end
        shifted = {adj, bin_i} << 1;
        bcd_o   = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_o   = shifted[BIN_W-1:0];
    end

endmodule

// File: rtl/ssd_bcd_value_feeder.sv
// Sequential 8-bit binary to two-digit BCD converter feeding the PmodSSD display.
// Build option: SSD_BCD_SATURATE_EN shows 9,9 for values above 99 instead of value mod 100.
module ssd_bcd_value_feeder
    import ssd_bcd_pkg::*;
(
    input  logic             i_clk_20mhz,
    input  logic             i_rst_20mhz,
    input  logic [BIN_W-1:0] i_value,
    input  logic             i_value_valid,
    output logic             o_ready,
    output logic [3:0]       o_value0,
    output logic [3:0]       o_value1,
    output logic             o_overflow,
    output logic             o_done
);

    state_e           state_q;
    logic [BIN_W-1:0] bin_q;
    bcd_t             bcd_q;
    logic [2:0]       cnt_q;
    logic [3:0]       value0_q;
    logic [3:0]       value1_q;
    logic             overflow_q;
    logic             done_q;

    bcd_t             bcd_d;
    logic [BIN_W-1:0] bin_d;

    bcd_dabble_step u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (bcd_d),
        .bin_o (bin_d)
    );

    always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
        if (!i_rst_20mhz) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            value0_q   <= '0;
            value1_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_value_valid) begin
                        bin_q   <= i_value;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(ITER_COUNT - 1)) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    if (bcd_q[BCD_W-1 -: 4] != 4'd0) begin
                        overflow_q <= 1'b1;
`ifdef SSD_BCD_SATURATE_EN
                        value1_q   <= 4'd9;
                        value0_q   <= 4'd9;
`else
                        value1_q   <= bcd_q[7:4];
                        value0_q   <= bcd_q[3:0];
`endif
                    end else begin
                        overflow_q <= 1'b0;
                        value1_q   <= bcd_q[7:4];
                        value0_q   <= bcd_q[3:0];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_value0   = value0_q;
    assign o_value1   = value1_q;
    assign o_overflow = overflow_q;
    assign o_done     = done_q;

endmodule

// File: doc/ssd_bcd_value_feeder.md
# ssd_bcd_value_feeder

Sequential binary-to-BCD converter. It sits directly upstream of `one_pmod_ssd_display` and drives that block's `i_value0`/`i_value1` so the PmodSSD shows a decimal count instead of hex. An 8-bit binary sample is accepted through a valid/ready handshake and converted by iterative shift-add-3 (double dabble). Two registered BCD digits, an overflow flag and a one-cycle done pulse are presented to the display stage.

## Interface
- No parameters; widths fixed by package constants (8-bit binary in, 3 internal BCD digits, 2 output digits).
- `i_clk_20mhz`  in  1  system clock, 20 MHz, single clock domain.
- `i_rst_20mhz`  in  1  reset, asynchronous, active-low.
- `i_value`  in  8  unsigned binary value to convert.
- `i_value_valid`  in  1  `i_value` is offered.
- `o_ready`  out  1  block is idle and accepts `i_value` on this edge.
- `o_value0`  out  4  ones BCD digit, to `one_pmod_ssd_display.i_value0`.
- `o_value1`  out  4  tens BCD digit, to `one_pmod_ssd_display.i_value1`.
- `o_overflow`  out  1  last converted value exceeded 99.
- `o_done`  out  1  one-cycle pulse when the outputs update.

## Operation
- States:
  - IDLE: `o_ready`=1.
  - SHIFT: 8 iterations.
  - LATCH: one cycle.
- `o_ready` is decoded combinationally as state==IDLE.
- IDLE → SHIFT when `i_value_valid`=1 at an edge.
  - Captures `i_value` into an 8-bit shift register.
  - Clears the 12-bit BCD accumulator (hundreds/tens/ones).
  - Clears the iteration counter (3-bit).
- SHIFT, each edge:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - Counter increments.
  - After the iteration with counter==7 → LATCH.
- LATCH, one edge:
  - If hundreds≠0: `o_overflow`←1 and digits per Configuration.
  - Else: `o_overflow`←0, `o_value1`←tens, `o_value0`←ones.
  - `o_done`←1, state→IDLE.
- `o_done` is high for exactly one cycle, after the LATCH edge.
- Outputs hold their last converted value indefinitely between conversions.
- Handshake:
  - `i_value_valid` while busy is ignored; there is no queuing.
  - The producer holds `i_value`/`i_value_valid` until it sees `o_ready`=1 at an edge.
  - `i_value` changes while busy have no effect.
- Reset values, applied asynchronously on `i_rst_20mhz`=0:
  - state IDLE (`o_ready`=1).
  - `o_value0`=0, `o_value1`=0, `o_overflow`=0, `o_done`=0.
  - Internal registers are cleared.
- Reset mid-conversion discards the conversion; no `o_done` is produced.
- Widths:
  - Add-3 operates per 4-bit nibble with no carry between nibbles.
  - Max input 255 gives hundreds=2, so the 12-bit accumulator never overflows.

## Timing
- Accept edge N (`i_value_valid`=1, `o_ready`=1).
- SHIFT on edges N+1..N+8; LATCH edge N+9.
- New digits and `o_done`=1 are visible after edge N+9.
- `o_ready` is low from after edge N until after edge N+9.
- Earliest next accept is edge N+10; sustained throughput is 1 value per 10 cycles.
- A continuously asserted valid with a constant value reconverts every 10 cycles. The digits stay stable (no glitch), and `o_done` pulses every 10 cycles.
- Reset deassertion is synchronised externally; the first accept can occur on the first edge after release.

## Configuration
- `SSD_BCD_SATURATE_EN` defined: values >99 display 9,9 and `o_overflow`=1.
- `SSD_BCD_SATURATE_EN` undefined: values >99 display tens/ones of the value (value mod 100) and `o_overflow`=1.
- Values ≤99 behave identically in both builds.

## Structure
- Package `ssd_bcd_pkg` holds:
  - State enum (IDLE, SHIFT, LATCH).
  - Constants: binary width 8, iteration count 8, BCD digit count 3.
  - Typedef for the 12-bit BCD accumulator.
- One natural sub-module: `bcd_dabble_step`.
  - Combinational; takes {bcd[11:0], bin[7:0]}.
  - Returns the add-3-then-shift result.
  - Instanced once inside the FSM datapath.

## Test plan
- Reset released, `i_value`=0x2A (42), valid for one accept edge → after 10 cycles `o_value1`=4, `o_value0`=2, `o_overflow`=0, single `o_done` pulse.
- `i_value`=99 → digits 9,9, `o_overflow`=0. Then `i_value`=0 → digits 0,0.
- `i_value`=100 → saturate build: 9,9, `o_overflow`=1. Non-saturate build: 0,0, `o_overflow`=1.
- `i_value`=255 → saturate build: 9,9, `o_overflow`=1. Non-saturate build: 5,5, `o_overflow`=1.
- Accept 0x37 (55); change `i_value` to 0x05 and keep valid high during the busy window → first result 5,5; `o_ready` low edges N+1..N+9; second accept at N+10 yields 0,5 at N+19.
- Accept 77, assert reset at cycle N+4 for 2 cycles → outputs 0/0/0, `o_ready`=1 immediately, no `o_done`. A subsequent 12 converts to 1,2 normally.
